// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Each operation takes one latch edge, one prep edge, DATA_WIDTH iteration edges and one fix-up edge.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      op_reg, op_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic [W-1:0]    x_reg, x_next;
  logic [2*W-1:0]  acc_reg, acc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;
  logic            done_reg, done_next;
  logic [W-1:0]    hi_reg, hi_next;
  logic [W-1:0]    lo_reg, lo_next;

  logic            is_div;
  logic            signed_op;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W:0]      add_sum;
  logic [W:0]      div_shift;
  logic [W-1:0]    div_diff;
  logic            div_ge;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;

  assign is_div    = op_reg[1];
  assign signed_op = ~op_reg[0];
  assign mag_a     = (signed_op && a_reg[W-1]) ? -a_reg : a_reg;
  assign mag_b     = (signed_op && b_reg[W-1]) ? -b_reg : b_reg;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign add_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, x_reg} : {(W+1){1'b0}});
  assign div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
  assign div_ge    = (div_shift >= {1'b0, x_reg});
  assign div_diff  = div_shift[W-1:0] - x_reg;

  assign prod_fix  = neg_q_reg ? -acc_reg : acc_reg;
  assign quo_fix   = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
  assign rem_fix   = neg_r_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    x_next     = x_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    done_next  = 1'b0;
    hi_next    = hi_reg;
    lo_next    = lo_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          op_next    = op;
          a_next     = operand_a;
          b_next     = operand_b;
          state_next = PREP;
        end else begin
          if (mthi) hi_next = operand_a;
          if (mtlo) lo_next = operand_a;
        end
      end
      PREP: begin
        neg_q_next = signed_op & (a_reg[W-1] ^ b_reg[W-1]);
        neg_r_next = signed_op & a_reg[W-1];
        count_next = '0;
        acc_next   = is_div ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
        x_next     = is_div ? mag_b : mag_a;
        state_next = CALC;
      end
      CALC: begin
        if (is_div)
          acc_next = {(div_ge ? div_diff : div_shift[W-1:0]), acc_reg[W-2:0], div_ge};
        else
          acc_next = {add_sum, acc_reg[W-1:1]};
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(W-1)) state_next = FIX;
      end
      FIX: begin
        if (!flush) begin
          if (is_div) begin
            hi_next = rem_fix;
            lo_next = quo_fix;
          end else begin
            hi_next = prod_fix[2*W-1:W];
            lo_next = prod_fix[W-1:0];
          end
          done_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // An abort discards the in-flight operation without touching HI/LO
    if (flush && state_reg != IDLE) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      x_reg     <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      done_reg  <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      x_reg     <= x_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      done_reg  <= done_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table of operations plus hand-written
// sequences for MT writes, ignored inputs while busy, flush and mid-operation reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  localparam int K_NONE = 0, K_IGNORE = 1, K_FLUSH = 2, K_RST = 3, K_START_MT = 4;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one operation; optionally injects an event sampled at edge 'at' (edge 1 = start sample).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int kind, input int at,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (kind == K_START_MT) begin mthi = 1'b1; mtlo = 1'b1; end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0; rst = 1'b0;
      if (i == at - 1) begin
        case (kind)
          K_IGNORE: begin
            start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
            op = OP_DIVU; operand_a = 32'hDEADBEEF; operand_b = 32'h1;
          end
          K_FLUSH: flush = 1'b1;
          K_RST:   rst = 1'b1;
          default: ;
        endcase
      end
      if (i == 1) check({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
      if (i == 34 && (kind == K_NONE || kind == K_IGNORE || kind == K_START_MT))
        check({nm, " busy_before_fix"}, {31'd0, busy}, 32'd1);
      if ((kind == K_FLUSH || kind == K_RST) && i == at)
        check({nm, " busy_after_abort"}, {31'd0, busy}, 32'd0);
      if (done && !seen) begin
        seen = 1;
        cyc  = i;
        check({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
      end
      if (seen) break;
    end
    if (kind == K_FLUSH || kind == K_RST) begin
      check({nm, " no_done"}, {31'd0, seen}, 32'd0);
    end else begin
      check({nm, " latency"}, cyc, 32'd35);
    end
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h done_edge=%0d", nm, o, a, b, hi, lo, cyc);
    if (seen) begin
      @(posedge clk); #1;
      check({nm, " done_one_cycle"}, {31'd0, done}, 32'd0);
    end
  endtask

  task automatic mt_write(input bit h, input bit l, input logic [31:0] v,
                          input logic [31:0] eh, input logic [31:0] el, input string nm);
    @(negedge clk);
    mthi = h; mtlo = l; operand_a = v;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check({nm, " hi"}, hi, eh);
    check({nm, " lo"}, lo, el);
    check({nm, " done"}, {31'd0, done}, 32'd0);
    $display("[TB] %s v=%h -> hi=%h lo=%h", nm, v, hi, lo);
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
    vecs[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{OP_MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, K_NONE, 0, vecs[i].hi, vecs[i].lo,
             $sformatf("vec%0d", i));

    // MT writes: HI only, LO only, both together
    mt_write(1'b1, 1'b0, 32'hAAAA0000, 32'hAAAA0000, 32'h00000002, "mthi");
    mt_write(1'b0, 1'b1, 32'h01234567, 32'hAAAA0000, 32'h01234567, "mtlo");
    mt_write(1'b1, 1'b1, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D, "mthi_mtlo");

    // Start, MT and operand changes while busy are ignored
    run_op(OP_MULTU, 32'd3, 32'd5, K_IGNORE, 10, 32'd0, 32'd15, "busy_ignore");
    // Start wins over a simultaneous MT write
    run_op(OP_MULTU, 32'd3, 32'd5, K_START_MT, 0, 32'd0, 32'd15, "start_vs_mt");

    // Flush in IDLE has no effect
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("idle_flush busy", {31'd0, busy}, 32'd0);
    check("idle_flush lo", lo, 32'd15);

    mt_write(1'b1, 1'b1, 32'h00000066, 32'h00000066, 32'h00000066, "preset_hi");
    mt_write(1'b0, 1'b1, 32'h00000055, 32'h00000066, 32'h00000055, "preset_lo");
    run_op(OP_DIVU, 32'd100, 32'd7, K_FLUSH, 20, 32'h66, 32'h55, "flush_mid");
    // Flush landing on the fix-up edge must also leave HI/LO untouched
    run_op(OP_DIVU, 32'd100, 32'd7, K_FLUSH, 35, 32'h66, 32'h55, "flush_fix");
    run_op(OP_DIVU, 32'd100, 32'd7, K_RST, 15, 32'h0, 32'h0, "rst_mid");

    // Unit is usable again after the abort
    run_op(OP_DIVU, 32'd100, 32'd7, K_NONE, 0, 32'd2, 32'd14, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the 32-bit 3:1 operand-forwarding muxes.
- Consumes the forwarded rs/rt values and executes MULT, MULTU, DIV and DIVU over multiple cycles, holding results in internal HI/LO registers.
- Exposes busy so hazard logic stalls MFHI/MFLO/new mul-div ops until done; also services MTHI/MTLO.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width; iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  DATA_WIDTH  forwarded rs (multiplicand/dividend)
- operand_b  input  DATA_WIDTH  forwarded rt (multiplier/divisor)
- mthi  input  1  write operand_a into HI (IDLE only)
- mtlo  input  1  write operand_a into LO (IDLE only)
- flush  input  1  abort in-flight operation; HI/LO unchanged
- busy  output  1  high while operation in flight
- done  output  1  one-cycle pulse when HI/LO take new result
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset is synchronous and active-high: one clock, rst sampled on rising clk edge. Reset: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0; rst overrides all inputs including mid-operation.
- States: IDLE -> PREP -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge E0: latch op, operand_a, operand_b; busy=1; go PREP.
- PREP (E1): for signed ops take magnitudes, record result signs (product sign = a^b; quotient sign = a^b; remainder sign = a); counter=0; go CALC.
- CALC (E2..E33): one iteration per cycle, 32 iterations.
  - Multiply: radix-2 shift-add into 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder, 32-bit quotient.
  - After iteration 31, go FIX.
- FIX (E34): apply sign correction; write HI/LO.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
  - busy=0, done=1 for the cycle after E34; go IDLE.
- Total latency: 35 edges from start sample to hi/lo valid; done and new hi/lo are visible in the same cycle.
- busy is 1 from the cycle after E0 through the cycle after E33 inclusive.
- start, mthi and mtlo while busy: ignored (hazard logic must stall).
- IDLE, start=1 with mthi or mtlo in the same cycle: start wins; the MT write is dropped.
- IDLE, mthi and mtlo both 1 (no start): both HI and LO take operand_a.
- MT writes take effect next edge; done is not asserted for MT writes.
- flush=1 in PREP/CALC/FIX: return to IDLE next edge, busy=0, done=0, HI/LO retain prior values. flush in IDLE: no effect. rst dominates flush.
- Divide by zero (natural restoring result): DIVU gives LO=all ones, HI=operand_a. DIV gives LO=all ones if a>=0, else 1; HI=operand_a.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Remainder carries the sign of the dividend; quotient truncates toward zero.
- done asserted only in the single cycle after FIX, never otherwise.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 35 edges HI=0xFFFFFFFE, LO=0x00000001, done one cycle, busy falls same cycle.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU a=100 b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI a=0xAAAA0000 in IDLE -> hi=0xAAAA0000 next cycle. Then start MULTU 3*5; at cycle 10 assert start, mtlo, mthi -> all ignored; final LO=15, HI=0.
- Start DIVU 100/7 after LO=0x55; flush at cycle 20 -> busy=0 next cycle, done never pulses, LO=0x55. Separately, rst at cycle 15 mid-op -> HI=LO=0, busy=0.
